// File: rtl/audio_echo_pkg.sv
// Shared definitions for the echo effect: controller state encoding and
// delay RAM address sizing.
package audio_echo_pkg;

  // Controller sequencing states.
  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_IDLE   = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_OUTPUT = 3'd4
  } echo_state_t;

  // Delay RAM address width: frame index bits plus one channel bit.
  function automatic int addr_width(input int d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/delay_ram_sp.sv
// Inferred single-port delay RAM, 2*delay_samples words of audio_width bits,
// with a registered read port. Placed beside the controller, not inside it.
module delay_ram_sp
  import audio_echo_pkg::*;
#(
  parameter int audio_width   = 16,
  parameter int delay_samples = 4096
) (
  input  logic                                 clk,
  input  logic [addr_width(delay_samples)-1:0] addr,
  input  logic                                 we,
  input  logic [audio_width-1:0]               wdata,
  output logic [audio_width-1:0]               rdata
);

  logic [audio_width-1:0] mem_r [2*delay_samples];

  // Synchronous write and registered read of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/echo_delay_memory_controller.sv
// Sequences the single-port delay RAM for the echo stage: zero-fills the RAM
// after reset, then for each accepted sample reads the old slot, overwrites it
// with the new sample and presents the dry/delayed pair downstream.
module echo_delay_memory_controller
  import audio_echo_pkg::*;
#(
  parameter int audio_width   = 16,
  parameter int delay_samples = 4096
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 i_valid,
  output logic                                 i_ready,
  input  logic                                 i_is_left,
  input  logic [audio_width-1:0]               i_audio,
  output logic                                 o_valid,
  input  logic                                 o_ready,
  output logic                                 o_is_left,
  output logic [audio_width-1:0]               o_dry,
  output logic [audio_width-1:0]               o_delayed,
  output logic [addr_width(delay_samples)-1:0] ram_addr,
  output logic                                 ram_we,
  output logic [audio_width-1:0]               ram_wdata,
  input  logic [audio_width-1:0]               ram_rdata
);

  localparam int fw = $clog2(delay_samples);
  localparam int aw = addr_width(delay_samples);
  // Clear counter is one bit wider than the address so it can reach 2*delay_samples.
  localparam logic [aw:0] clear_len = (aw+1)'(2 * delay_samples);

  echo_state_t            state_r;
  logic [fw-1:0]          frame_index_r;
  logic [aw:0]            clr_cnt_r;
  logic                   lat_left_r;
  logic [audio_width-1:0] lat_audio_r;

  // Single FSM: state, frame index, latched sample and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ST_CLEAR;
      frame_index_r <= '0;
      clr_cnt_r     <= '0;
      lat_left_r    <= 1'b0;
      lat_audio_r   <= {audio_width{1'b0}};
      i_ready       <= 1'b0;
      o_valid       <= 1'b0;
      o_is_left     <= 1'b0;
      o_dry         <= {audio_width{1'b0}};
      o_delayed     <= {audio_width{1'b0}};
      ram_we        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= {audio_width{1'b0}};
    end else begin
      case (state_r)
        ST_CLEAR: begin
          if (clr_cnt_r == clear_len) begin
            // Every slot written; open the input on this cycle.
            ram_we  <= 1'b0;
            i_ready <= 1'b1;
            state_r <= ST_IDLE;
          end else begin
            ram_we    <= 1'b1;
            ram_wdata <= {audio_width{1'b0}};
            ram_addr  <= clr_cnt_r[aw-1:0];
            clr_cnt_r <= clr_cnt_r + (aw+1)'(1'b1);
          end
        end
        ST_IDLE: begin
          ram_we <= 1'b0;
          if (i_valid) begin
            lat_left_r  <= i_is_left;
            lat_audio_r <= i_audio;
            ram_addr    <= {frame_index_r, i_is_left};
            i_ready     <= 1'b0;
            state_r     <= ST_READ;
          end else begin
            i_ready <= 1'b1;
          end
        end
        ST_READ: begin
          // Read was issued last cycle; data lands during WRITE.
          ram_we    <= 1'b1;
          ram_wdata <= lat_audio_r;
          state_r   <= ST_WRITE;
        end
        ST_WRITE: begin
          ram_we    <= 1'b0;
          o_delayed <= ram_rdata;
          o_dry     <= lat_audio_r;
          o_is_left <= lat_left_r;
          o_valid   <= 1'b1;
          // Only a right-channel sample closes a frame.
          if (!lat_left_r) begin
            frame_index_r <= frame_index_r + fw'(1'b1);
          end
          state_r <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (o_ready) begin
            o_valid <= 1'b0;
            i_ready <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          ram_we    <= 1'b0;
          i_ready   <= 1'b0;
          o_valid   <= 1'b0;
          clr_cnt_r <= '0;
          state_r   <= ST_CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_echo_delay_memory_controller.sv
// Randomized self-checking bench for echo_delay_memory_controller with the
// delay RAM beside it; expected values come from a slot-array reference model.
module tb_echo_delay_memory_controller;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          i_is_left = 1'b0;
  logic [W-1:0]  i_audio = 16'h0000;
  logic          o_valid;
  logic          o_ready = 1'b0;
  logic          o_is_left;
  logic [W-1:0]  o_dry;
  logic [W-1:0]  o_delayed;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [W-1:0]  ram_wdata;
  logic [W-1:0]  ram_rdata;

  int errors = 0;
  int checks = 0;

  // Reference model: one word per {frame, channel} slot plus the frame pointer.
  logic [W-1:0] model_mem [2*D];
  int           model_frame;

  echo_delay_memory_controller #(.audio_width(W), .delay_samples(D)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_is_left(i_is_left), .i_audio(i_audio),
    .o_valid(o_valid), .o_ready(o_ready), .o_is_left(o_is_left),
    .o_dry(o_dry), .o_delayed(o_delayed),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  delay_ram_sp #(.audio_width(W), .delay_samples(D)) ram (
    .clk(clk), .addr(ram_addr), .we(ram_we), .wdata(ram_wdata), .rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2*D; i++) model_mem[i] = 16'h0000;
    model_frame = 0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    i_valid = 1'b0;
    o_ready = 1'b0;
    step();
    check("rst_i_ready", i_ready, 0);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_is_left", o_is_left, 0);
    check("rst_o_dry", o_dry, 0);
    check("rst_o_delayed", o_delayed, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    step();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic check_clear();
    for (int k = 0; k < 2*D; k++) begin
      step();
      check("clr_we", ram_we, 1);
      check("clr_addr", ram_addr, k);
      check("clr_wdata", ram_wdata, 0);
      check("clr_i_ready", i_ready, 0);
    end
    step();
    check("clr_done_i_ready", i_ready, 1);
    check("clr_done_we", ram_we, 0);
  endtask

  task automatic send(input logic left, input logic [W-1:0] audio, input int stall);
    int            n;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  exp_del;
    n = 0;
    while (!i_ready && n < 50) begin
      step();
      n++;
    end
    if (!i_ready) begin
      check("accept_timeout", 0, 1);
      return;
    end
    exp_addr = AW'(model_frame * 2 + int'(left));
    exp_del  = model_mem[exp_addr];
    i_valid = 1'b1;
    i_is_left = left;
    i_audio = audio;
    o_ready = (stall == 0);
    step();
    // Scramble inputs so the bench notices if the latched copy is not used.
    i_valid = 1'b0;
    i_is_left = 1'($urandom);
    i_audio = W'($urandom);
    check("read_addr", ram_addr, exp_addr);
    check("read_we", ram_we, 0);
    check("read_o_valid", o_valid, 0);
    check("read_i_ready", i_ready, 0);
    step();
    check("write_we", ram_we, 1);
    check("write_addr", ram_addr, exp_addr);
    check("write_data", ram_wdata, audio);
    check("write_o_valid", o_valid, 0);
    step();
    check("out_valid", o_valid, 1);
    check("out_dry", o_dry, audio);
    check("out_delayed", o_delayed, exp_del);
    check("out_is_left", o_is_left, left);
    check("out_we", ram_we, 0);
    check("out_i_ready", i_ready, 0);
    for (int s = 0; s < stall; s++) begin
      step();
      check("stall_valid", o_valid, 1);
      check("stall_dry", o_dry, audio);
      check("stall_delayed", o_delayed, exp_del);
      check("stall_is_left", o_is_left, left);
      check("stall_i_ready", i_ready, 0);
      check("stall_we", ram_we, 0);
    end
    o_ready = 1'b1;
    step();
    check("done_o_valid", o_valid, 0);
    check("done_i_ready", i_ready, 1);
    o_ready = 1'b0;
    model_mem[exp_addr] = audio;
    if (!left) model_frame = (model_frame + 1) % D;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state and zero-fill sequence.
    apply_reset();
    check_clear();

    // First stereo frame sees silent echoes.
    send(1'b1, 16'h1111, 0);
    send(1'b0, 16'h2222, 0);

    // Six frames from a clean RAM: frames 5 and 6 echo frames 1 and 2.
    apply_reset();
    check_clear();
    for (int k = 1; k <= 6; k++) begin
      send(1'b1, W'(k), 0);
      send(1'b0, W'(16'h0100 + k), 0);
    end
    check("wrap_frame_ptr", model_frame, 2);

    // Long backpressure at OUTPUT.
    send(1'b1, 16'h5A5A, 20);

    // Repeated left samples share a slot; the right sample follows in the same frame.
    send(1'b1, 16'hAAAA, 0);
    send(1'b1, 16'hBBBB, 1);
    send(1'b0, 16'hCCCC, 0);

    // Reset during WRITE drops the sample and restarts the full clear.
    begin : reset_in_write
      int n;
      n = 0;
      while (!i_ready && n < 50) begin
        step();
        n++;
      end
      check("rw_ready", i_ready, 1);
      i_valid = 1'b1;
      i_is_left = 1'b0;
      i_audio = 16'h7777;
      step();
      i_valid = 1'b0;
      step();
      check("rw_in_write_we", ram_we, 1);
      apply_reset();
      check_clear();
    end
    send(1'b0, 16'h3333, 0);

    // Reset in the middle of CLEAR restarts it from address 0.
    apply_reset();
    repeat (3) step();
    check("mid_clear_we", ram_we, 1);
    check("mid_clear_addr", ram_addr, 2);
    apply_reset();
    check_clear();
    send(1'b1, 16'h4444, 0);

    // Randomized traffic: random channel order, data, idle gaps and backpressure.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send(1'($urandom_range(0, 1)), W'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
